// File: rtl/spi_transfer_controller.sv
// SPI mode-0 byte transfer controller driving an external 8-bit shift register.
// A byte is loaded into the shift register, shifted out MSB first with one
// strobe per SCLK rising edge, and the shift register's parallel output is
// captured when the byte completes.
// Optional feature: define SPI_CTRL_BURST_EN to chain bytes back-to-back
// while chip select stays asserted (a request accepted during CAPTURE skips SETUP).
module spi_transfer_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_tx_data,
  output logic       o_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_sclk,
  output logic       o_cs_n,
  output logic [1:0] o_sr_mode,
  output logic [7:0] o_sr_parallel,
  output logic       o_sr_slow_clk,
  output logic       o_sr_output_enable_n,
  input  logic [7:0] i_sr_parallel
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    SHIFT,
    TAIL,
    CAPTURE
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [1:0] SR_HOLD  = 2'b00;
  localparam logic [1:0] SR_SHIFT = 2'b10;
  localparam logic [1:0] SR_LOAD  = 2'b11;

  state_t     state;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] tx_byte;
`ifdef SPI_CTRL_BURST_EN
  logic       burst_q;
`endif

  assign o_sr_parallel = tx_byte;

  // Latch the outgoing byte whenever a request is accepted.
  always_ff @(posedge i_clk) begin
    if (i_start && o_ready) begin
      tx_byte <= i_tx_data;
    end
  end

  // Transfer sequencer; every output is registered and set for the state being entered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state                <= IDLE;
      div_cnt              <= 8'd0;
      bit_cnt              <= 3'd0;
      o_ready              <= 1'b1;
      o_rx_data            <= 8'h00;
      o_rx_valid           <= 1'b0;
      o_sclk               <= 1'b0;
      o_cs_n               <= 1'b1;
      o_sr_mode            <= SR_HOLD;
      o_sr_slow_clk        <= 1'b0;
      o_sr_output_enable_n <= 1'b1;
`ifdef SPI_CTRL_BURST_EN
      burst_q              <= 1'b0;
`endif
    end else begin
      o_rx_valid    <= 1'b0;
      o_sr_slow_clk <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state     <= LOAD;
            o_ready   <= 1'b0;
            o_sr_mode <= SR_LOAD;
`ifdef SPI_CTRL_BURST_EN
            burst_q   <= 1'b0;
`endif
          end
        end

        LOAD: begin
          o_sr_mode <= SR_HOLD;
          o_cs_n    <= 1'b0;
          div_cnt   <= 8'd0;
          bit_cnt   <= 3'd0;
`ifdef SPI_CTRL_BURST_EN
          // A chained byte already has CS asserted, so no setup time is needed.
          state     <= burst_q ? SHIFT : SETUP;
`else
          state     <= SETUP;
`endif
        end

        SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= 8'd0;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        SHIFT: begin
          o_sr_mode <= SR_HOLD;
          if (div_cnt == DIV_LAST) begin
            div_cnt <= 8'd0;
            if (!o_sclk) begin
              // Rising SCLK: shift strobe lasts only the first high cycle.
              o_sclk        <= 1'b1;
              o_sr_mode     <= SR_SHIFT;
              o_sr_slow_clk <= 1'b1;
            end else begin
              o_sclk  <= 1'b0;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= TAIL;
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        TAIL: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt              <= 8'd0;
            state                <= CAPTURE;
            o_sr_output_enable_n <= 1'b0;
`ifdef SPI_CTRL_BURST_EN
            o_ready              <= 1'b1;
`endif
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        CAPTURE: begin
          o_sr_output_enable_n <= 1'b1;
          o_rx_data            <= i_sr_parallel;
          o_rx_valid           <= 1'b1;
`ifdef SPI_CTRL_BURST_EN
          if (i_start) begin
            state     <= LOAD;
            o_ready   <= 1'b0;
            o_sr_mode <= SR_LOAD;
            burst_q   <= 1'b1;
          end else begin
            state   <= IDLE;
            o_cs_n  <= 1'b1;
            burst_q <= 1'b0;
          end
`else
          state   <= IDLE;
          o_cs_n  <= 1'b1;
          o_ready <= 1'b1;
`endif
        end

        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
          o_cs_n  <= 1'b1;
          o_sclk  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_transfer_controller.sv
// Directed bench for spi_transfer_controller: one instance with CLK_DIV=4 and
// one with CLK_DIV=1, each attached to a loopback shift-register model that
// rotates MOSI back into its LSB so the captured byte equals the sent byte.
module tb_spi_transfer_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start  [2];
  logic [7:0] tx     [2];
  logic       ready  [2];
  logic [7:0] rx     [2];
  logic       rxv    [2];
  logic       sclk   [2];
  logic       cs_n   [2];
  logic [1:0] mode   [2];
  logic [7:0] par    [2];
  logic       slow   [2];
  logic       oe_n   [2];
  logic [7:0] sr_in  [2];
  logic [7:0] sr     [2];

  spi_transfer_controller #(.CLK_DIV(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_tx_data(tx[0]),
    .o_ready(ready[0]), .o_rx_data(rx[0]), .o_rx_valid(rxv[0]),
    .o_sclk(sclk[0]), .o_cs_n(cs_n[0]), .o_sr_mode(mode[0]),
    .o_sr_parallel(par[0]), .o_sr_slow_clk(slow[0]),
    .o_sr_output_enable_n(oe_n[0]), .i_sr_parallel(sr_in[0])
  );

  spi_transfer_controller #(.CLK_DIV(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_tx_data(tx[1]),
    .o_ready(ready[1]), .o_rx_data(rx[1]), .o_rx_valid(rxv[1]),
    .o_sclk(sclk[1]), .o_cs_n(cs_n[1]), .o_sr_mode(mode[1]),
    .o_sr_parallel(par[1]), .o_sr_slow_clk(slow[1]),
    .o_sr_output_enable_n(oe_n[1]), .i_sr_parallel(sr_in[1])
  );

  // Shift register only drives its parallel output while enabled.
  assign sr_in[0] = oe_n[0] ? 8'h00 : sr[0];
  assign sr_in[1] = oe_n[1] ? 8'h00 : sr[1];

  // Loopback shift-register model: load, or rotate left (MOSI fed back to LSB).
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mode[k] === 2'b11) sr[k] <= par[k];
      else if (mode[k] === 2'b10) sr[k] <= {sr[k][6:0], sr[k][7]};
    end
  end

  int cyc = 0;
  int strobes [2] = '{0, 0};
  int rises   [2] = '{0, 0};
  int valids  [2] = '{0, 0};
  int loads   [2] = '{0, 0};
  int gaps    [2] = '{0, 0};
  int rdy_cap [2] = '{0, 0};
  int load_cyc   [2] = '{0, 0};
  int valid_cyc  [2] = '{0, 0};
  int first_rise [2] = '{0, 0};
  int last_rise  [2] = '{0, 0};
  int rise_since [2] = '{0, 0};
  logic prev_sclk [2];
  logic prev_cs   [2];

  // Event monitor sampled mid-cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (slow[k] === 1'b1) strobes[k]++;
      if (sclk[k] === 1'b1 && prev_sclk[k] === 1'b0) begin
        rises[k]++;
        if (rise_since[k] == 0) first_rise[k] = cyc;
        last_rise[k] = cyc;
        rise_since[k]++;
      end
      if (mode[k] === 2'b11) begin
        loads[k]++;
        load_cyc[k] = cyc;
        rise_since[k] = 0;
        if (prev_cs[k] === 1'b1) gaps[k]++;
      end
      if (rxv[k] === 1'b1) begin
        valids[k]++;
        valid_cyc[k] = cyc;
      end
      if (oe_n[k] === 1'b0 && ready[k] === 1'b1) rdy_cap[k]++;
      prev_sclk[k] = sclk[k];
      prev_cs[k] = cs_n[k];
    end
    cyc++;
  end

  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (cs_n[0] !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", cs_n[0]); end
    checks++; if (sclk[0] !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk[0]); end
    checks++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready[0]); end
    checks++; if (rx[0] !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx[0]); end
    checks++; if (mode[0] !== 2'b00 || oe_n[0] !== 1'b1 || slow[0] !== 1'b0 || rxv[0] !== 1'b0) begin
      errors++; $display("FAIL reset_sr_ctrl: got mode=%b oe_n=%b slow=%b valid=%b expected 00 1 0 0", mode[0], oe_n[0], slow[0], rxv[0]);
    end
    checks++; if (ready[1] !== 1'b1) begin errors++; $display("FAIL reset_ready_div1: got %b expected 1", ready[1]); end
  endtask

  task automatic test_single_byte();
    int s0, r0, v0, i;
    s0 = strobes[0]; r0 = rises[0]; v0 = valids[0];
    tx[0] = 8'hA5; start[0] = 1'b1;
    tick();
    start[0] = 1'b0; tx[0] = 8'h00;
    checks++; if (ready[0] !== 1'b0) begin errors++; $display("FAIL single_ready_low: got %b expected 0", ready[0]); end
    checks++; if (mode[0] !== 2'b11 || par[0] !== 8'hA5) begin
      errors++; $display("FAIL single_load: got mode=%b par=%h expected 11 a5", mode[0], par[0]);
    end
    tick(); tick();
    checks++; if (cs_n[0] !== 1'b0 || sclk[0] !== 1'b0 || mode[0] !== 2'b00) begin
      errors++; $display("FAIL single_setup: got cs_n=%b sclk=%b mode=%b expected 0 0 00", cs_n[0], sclk[0], mode[0]);
    end
    for (i = 0; i < 300 && valids[0] == v0; i++) tick();
    checks++; if (valids[0] == v0) begin errors++; $display("FAIL single_timeout: got no rx_valid expected one within 300 cycles"); end
    checks++; if (rx[0] !== 8'hA5) begin errors++; $display("FAIL single_rx_data: got %h expected a5", rx[0]); end
    checks++; if (strobes[0] - s0 != 8) begin errors++; $display("FAIL single_strobes: got %0d expected 8", strobes[0] - s0); end
    checks++; if (rises[0] - r0 != 8) begin errors++; $display("FAIL single_sclk_rises: got %0d expected 8", rises[0] - r0); end
    checks++; if (valid_cyc[0] - load_cyc[0] != 74) begin errors++; $display("FAIL single_latency: got %0d expected 74", valid_cyc[0] - load_cyc[0]); end
    checks++; if (first_rise[0] - load_cyc[0] != 9 || last_rise[0] - first_rise[0] != 56) begin
      errors++; $display("FAIL single_sclk_timing: got first=%0d span=%0d expected 9 56", first_rise[0] - load_cyc[0], last_rise[0] - first_rise[0]);
    end
    for (i = 0; i < 5; i++) tick();
    checks++; if (valids[0] - v0 != 1 || cs_n[0] !== 1'b1 || ready[0] !== 1'b1) begin
      errors++; $display("FAIL single_end: got valids=%0d cs_n=%b ready=%b expected 1 1 1", valids[0] - v0, cs_n[0], ready[0]);
    end
  endtask

  task automatic test_busy_request();
    int s0, v0, l0, i;
    s0 = strobes[0]; v0 = valids[0]; l0 = loads[0];
    tx[0] = 8'h5A; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (i = 0; i < 20; i++) tick();
    tx[0] = 8'h3C; start[0] = 1'b1;
    for (i = 0; i < 20; i++) tick();
    start[0] = 1'b0; tx[0] = 8'h00;
    for (i = 0; i < 150; i++) tick();
    checks++; if (rx[0] !== 8'h5A) begin errors++; $display("FAIL busy_rx_data: got %h expected 5a", rx[0]); end
    checks++; if (loads[0] - l0 != 1) begin errors++; $display("FAIL busy_loads: got %0d expected 1", loads[0] - l0); end
    checks++; if (strobes[0] - s0 != 8) begin errors++; $display("FAIL busy_strobes: got %0d expected 8", strobes[0] - s0); end
    checks++; if (valids[0] - v0 != 1) begin errors++; $display("FAIL busy_valids: got %0d expected 1", valids[0] - v0); end
    checks++; if (cs_n[0] !== 1'b1 || ready[0] !== 1'b1) begin errors++; $display("FAIL busy_idle: got cs_n=%b ready=%b expected 1 1", cs_n[0], ready[0]); end
  endtask

  task automatic test_mid_reset();
    int s0, v0, i;
    s0 = strobes[0]; v0 = valids[0];
    tx[0] = 8'hC3; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (i = 0; i < 200 && strobes[0] - s0 < 4; i++) tick();
    for (i = 0; i < 3; i++) tick();
    checks++; if (cs_n[0] !== 1'b0 || strobes[0] - s0 != 4) begin
      errors++; $display("FAIL midrst_in_shift: got cs_n=%b strobes=%0d expected 0 4", cs_n[0], strobes[0] - s0);
    end
    rst = 1'b1;
    tick();
    checks++; if (cs_n[0] !== 1'b1 || sclk[0] !== 1'b0) begin
      errors++; $display("FAIL midrst_abort: got cs_n=%b sclk=%b expected 1 0", cs_n[0], sclk[0]);
    end
    rst = 1'b0;
    tick();
    checks++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", ready[0]); end
    checks++; if (rx[0] !== 8'h00) begin errors++; $display("FAIL midrst_rx_cleared: got %h expected 00", rx[0]); end
    for (i = 0; i < 100; i++) tick();
    checks++; if (valids[0] != v0 || strobes[0] - s0 != 4) begin
      errors++; $display("FAIL midrst_no_valid: got valids=%0d strobes=%0d expected 0 4", valids[0] - v0, strobes[0] - s0);
    end
  endtask

  task automatic test_min_div();
    int s0, r0, v0, i;
    s0 = strobes[1]; r0 = rises[1]; v0 = valids[1];
    tx[1] = 8'h81; start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    for (i = 0; i < 100 && valids[1] == v0; i++) tick();
    checks++; if (valids[1] == v0) begin errors++; $display("FAIL div1_timeout: got no rx_valid expected one within 100 cycles"); end
    checks++; if (rx[1] !== 8'h81) begin errors++; $display("FAIL div1_rx_data: got %h expected 81", rx[1]); end
    checks++; if (strobes[1] - s0 != 8) begin errors++; $display("FAIL div1_strobes: got %0d expected 8", strobes[1] - s0); end
    checks++; if (rises[1] - r0 != 8) begin errors++; $display("FAIL div1_sclk_rises: got %0d expected 8", rises[1] - r0); end
    checks++; if (valid_cyc[1] - load_cyc[1] != 20) begin errors++; $display("FAIL div1_latency: got %0d expected 20", valid_cyc[1] - load_cyc[1]); end
    checks++; if (first_rise[1] - load_cyc[1] != 3 || last_rise[1] - first_rise[1] != 14) begin
      errors++; $display("FAIL div1_sclk_period: got first=%0d span=%0d expected 3 14", first_rise[1] - load_cyc[1], last_rise[1] - first_rise[1]);
    end
    tick(); tick();
    checks++; if (cs_n[1] !== 1'b1 || ready[1] !== 1'b1 || sclk[1] !== 1'b0) begin
      errors++; $display("FAIL div1_idle: got cs_n=%b ready=%b sclk=%b expected 1 1 0", cs_n[1], ready[1], sclk[1]);
    end
  endtask

`ifdef SPI_CTRL_BURST_EN
  task automatic test_back_to_back();
    int s0, v0, l0, g0, c0, hi, i;
    s0 = strobes[0]; v0 = valids[0]; l0 = loads[0]; g0 = gaps[0]; c0 = rdy_cap[0]; hi = 0;
    tx[0] = 8'h12; start[0] = 1'b1;
    tick();
    tx[0] = 8'h34;
    tick();
    for (i = 0; i < 300 && valids[0] - v0 < 1; i++) begin
      if (cs_n[0] === 1'b1 && !(ready[0] === 1'b1 && oe_n[0] === 1'b1)) hi++;
      tick();
    end
    start[0] = 1'b0;
    checks++; if (rx[0] !== 8'h12) begin errors++; $display("FAIL burst_first_rx: got %h expected 12", rx[0]); end
    for (i = 0; i < 300 && valids[0] - v0 < 2; i++) begin
      if (cs_n[0] === 1'b1 && !(ready[0] === 1'b1 && oe_n[0] === 1'b1)) hi++;
      tick();
    end
    checks++; if (rx[0] !== 8'h34) begin errors++; $display("FAIL burst_second_rx: got %h expected 34", rx[0]); end
    checks++; if (strobes[0] - s0 != 16) begin errors++; $display("FAIL burst_strobes: got %0d expected 16", strobes[0] - s0); end
    checks++; if (valids[0] - v0 != 2) begin errors++; $display("FAIL burst_valids: got %0d expected 2", valids[0] - v0); end
    checks++; if (hi != 0 || gaps[0] - g0 != 1) begin
      errors++; $display("FAIL burst_cs_held: got cs_high=%0d idle_gaps=%0d expected 0 1", hi, gaps[0] - g0);
    end
    checks++; if (loads[0] - l0 != 2 || valid_cyc[0] - load_cyc[0] != 70) begin
      errors++; $display("FAIL burst_no_setup: got loads=%0d latency=%0d expected 2 70", loads[0] - l0, valid_cyc[0] - load_cyc[0]);
    end
    checks++; if (rdy_cap[0] - c0 != 2) begin errors++; $display("FAIL burst_ready_in_capture: got %0d expected 2", rdy_cap[0] - c0); end
  endtask
`else
  task automatic test_capture_request();
    int v0, l0, g0, c0, i;
    v0 = valids[0]; l0 = loads[0]; g0 = gaps[0]; c0 = rdy_cap[0];
    tx[0] = 8'h0F; start[0] = 1'b1;
    for (i = 0; i < 400 && valids[0] - v0 < 2; i++) tick();
    start[0] = 1'b0;
    for (i = 0; i < 100; i++) tick();
    checks++; if (rx[0] !== 8'h0F) begin errors++; $display("FAIL nob_rx_data: got %h expected 0f", rx[0]); end
    checks++; if (loads[0] - l0 != 3 || gaps[0] - g0 != 3) begin
      errors++; $display("FAIL nob_cs_gap: got loads=%0d gaps=%0d expected 3 3", loads[0] - l0, gaps[0] - g0);
    end
    checks++; if (rdy_cap[0] - c0 != 0) begin errors++; $display("FAIL nob_ready_in_capture: got %0d expected 0", rdy_cap[0] - c0); end
    checks++; if (valids[0] - v0 != 3) begin errors++; $display("FAIL nob_valids: got %0d expected 3", valids[0] - v0); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    start[0] = 1'b0; start[1] = 1'b0;
    tx[0] = 8'h00; tx[1] = 8'h00;
    test_reset();
    test_single_byte();
    test_busy_request();
    test_mid_reset();
    test_min_div();
`ifdef SPI_CTRL_BURST_EN
    test_back_to_back();
`else
    test_capture_request();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_transfer_controller.md
SPI_TRANSFER_CONTROLLER -- requirements
Module: spi_transfer_controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: i_clk cycles per SCLK half-period; legal range 1-255.
REQ-002 SHALL have port i_clk, input, 1: the single clock for all logic.
REQ-003 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port i_start, input, 1: transfer request, qualified by o_ready.
REQ-005 SHALL have port i_tx_data, input, 8: byte to transmit, sampled when i_start & o_ready.
REQ-006 SHALL have port o_ready, output, 1: high only in IDLE.
REQ-007 SHALL have port o_rx_data, output, 8: last received byte, held until the next capture.
REQ-008 SHALL have port o_rx_valid, output, 1: one-cycle pulse when o_rx_data updates.
REQ-009 SHALL have port o_sclk, output, 1: SPI clock, mode 0, idle low.
REQ-010 SHALL have port o_cs_n, output, 1: chip select, active-low.
REQ-011 SHALL have port o_sr_mode, output, 2: shift-register mode (11 load, 10 left shift, 00 hold).
REQ-012 SHALL have port o_sr_parallel, output, 8: shift-register parallel load data.
REQ-013 SHALL have port o_sr_slow_clk, output, 1: one-cycle shift strobe.
REQ-014 SHALL have port o_sr_output_enable_n, output, 1: shift-register parallel output enable, active-low.
REQ-015 SHALL have port i_sr_parallel, input, 8: shift-register parallel output.

Function
REQ-016 SHALL implement an FSM with states IDLE, LOAD, SETUP, SHIFT, TAIL and CAPTURE.
REQ-017 IDLE: when i_start=1, the FSM SHALL latch i_tx_data and enter LOAD on the next edge; o_ready SHALL be 0 in every state except IDLE.
REQ-018 LOAD: SHALL last 1 cycle, with o_sr_mode=11 and o_sr_parallel=latched byte; o_sr_mode SHALL be 00 in every other state.
REQ-019 SETUP: SHALL last CLK_DIV cycles, with o_cs_n=0 and o_sclk=0.
REQ-020 SHIFT: SHALL transfer 8 bits, each bit being CLK_DIV cycles with o_sclk=0 followed by CLK_DIV cycles with o_sclk=1.
REQ-021 SHIFT: on the first cycle of each o_sclk high phase, o_sr_mode SHALL be 10 and o_sr_slow_clk SHALL be 1 for exactly 1 cycle.
REQ-022 SHIFT: a 3-bit counter SHALL count bits 0-7; at the end of the high phase of bit 7, the FSM SHALL enter TAIL.
REQ-023 TAIL: SHALL last CLK_DIV cycles, with o_sclk=0 and o_cs_n=0.
REQ-024 CAPTURE: SHALL last 1 cycle, with o_sr_output_enable_n=0 and i_sr_parallel registered into o_rx_data.
REQ-025 o_rx_valid SHALL pulse high on the cycle after CAPTURE; o_sr_output_enable_n SHALL be 1 in every other cycle.
REQ-026 After CAPTURE, the FSM SHALL return to IDLE with o_cs_n=1; a full transfer SHALL take 1+CLK_DIV+16*CLK_DIV+CLK_DIV+1 cycles from LOAD to IDLE.
REQ-027 i_start while o_ready=0 SHALL be ignored and not queued.
REQ-028 o_sclk SHALL come directly from a register, glitch-free, and SHALL never be high outside SHIFT.
REQ-029 With CLK_DIV=1, SCLK SHALL be i_clk/2 and every phase SHALL be 1 cycle.

Reset
REQ-030 While i_rst=1 at a clock edge, state SHALL be IDLE, o_cs_n=1, o_sclk=0, o_sr_mode=00, o_sr_slow_clk=0, o_sr_output_enable_n=1, o_rx_data=0, o_rx_valid=0 and counters=0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer on that edge, with no o_rx_valid pulse and o_cs_n=1 on the following cycle.
REQ-032 o_ready SHALL be 1 on the first cycle after reset is released.

Configuration
REQ-033 Macro SPI_CTRL_BURST_EN, when defined: if i_start=1 during CAPTURE, the FSM SHALL latch i_tx_data and go to LOAD then directly to SHIFT, skipping SETUP, with o_cs_n held 0 throughout.
REQ-034 With SPI_CTRL_BURST_EN defined, o_ready SHALL also be 1 during CAPTURE.
REQ-035 When SPI_CTRL_BURST_EN is undefined, i_start during CAPTURE SHALL be ignored and o_cs_n SHALL always deassert between bytes.

Verification
REQ-036 Reset check: with CLK_DIV=4, drive i_rst=1 for 2 cycles then release -> o_cs_n=1, o_sclk=0, o_ready=1 and o_rx_data=00.
REQ-037 Single byte: i_start with i_tx_data=A5, model echoing MOSI into i_sr_parallel=A5 -> exactly 8 o_sr_slow_clk pulses, 8 SCLK rises, o_rx_data=A5 with o_rx_valid pulse 74 cycles after LOAD (CLK_DIV=4).
REQ-038 Busy request: i_start=1 with 3C during SHIFT -> ignored; only the first byte is transferred and o_cs_n returns to 1.
REQ-039 Mid-transfer reset: i_rst=1 after bit 3 -> o_cs_n=1 and o_sclk=0 next cycle, no o_rx_valid pulse, o_ready=1 after release.
REQ-040 Minimum divider: CLK_DIV=1, byte 81 -> SCLK period 2 cycles, 8 strobes, o_rx_valid 20 cycles after LOAD.
REQ-041 Burst: with SPI_CTRL_BURST_EN defined, bytes 12 then 34 back-to-back -> o_cs_n stays low across both, 16 strobes total, two o_rx_valid pulses.
